uart_rx_packetizer: RTL and testbench

//  Sits directly downstream of uart_wrapper's RX FIFO (rd_data/rx_empty/rd_uart). Pops received bytes,

---
 rtl/uart_rx_packetizer_if.sv | 29 ++
 rtl/uart_rx_packetizer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_uart_rx_packetizer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_packetizer_if.sv
// Byte-stream bundle: uart_wrapper RX FIFO side, validated payload stream side, and frame status.
// The packetizer uses the slave modport; the FIFO/consumer environment uses master.
interface uart_rx_packetizer_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_empty;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rx_err;
    logic                 rd_uart;
    logic [DATA_BITS-1:0] pkt_data;
    logic                 pkt_valid;
    logic                 pkt_last;
    logic                 pkt_ready;
    logic                 pkt_good;
    logic                 pkt_bad;
    logic [1:0]           err_code;
    logic [15:0]          good_cnt;
    logic [15:0]          bad_cnt;

    modport slave (
        input  rx_empty, rd_data, rx_err, pkt_ready,
        output rd_uart, pkt_data, pkt_valid, pkt_last, pkt_good, pkt_bad, err_code, good_cnt, bad_cnt
    );

    modport master (
        output rx_empty, rd_data, rx_err, pkt_ready,
        input  rd_uart, pkt_data, pkt_valid, pkt_last, pkt_good, pkt_bad, err_code, good_cnt, bad_cnt
    );
endinterface

// File: rtl/uart_rx_packetizer.sv
// Pops bytes from the uart_wrapper RX FIFO, frames SYNC/LEN/payload/CHK, and streams out only
// checksum-valid payloads. Optional inter-byte timeout is enabled by defining PKT_TIMEOUT_EN.
module uart_rx_packetizer #(
    parameter int                   DATA_BITS      = 8,
    parameter int                   MAX_LEN        = 16,
    parameter logic [DATA_BITS-1:0] SYNC_BYTE      = 8'hA5,
    parameter int                   TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_rx_packetizer_if.slave  bus
);

    localparam int DEPTH = (MAX_LEN < 2) ? 2 : MAX_LEN;
    localparam int IW    = $clog2(DEPTH);
    localparam int LW    = $clog2(MAX_LEN + 1);

    localparam logic [1:0] ERR_RX  = 2'b00;
    localparam logic [1:0] ERR_LEN = 2'b01;
    localparam logic [1:0] ERR_CHK = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_EMIT    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [LW-1:0]        len_q, len_d;
    logic [LW-1:0]        idx_q, idx_d;
    logic [LW-1:0]        rd_idx_q, rd_idx_d;
    logic [DATA_BITS-1:0] chk_q, chk_d;
    logic [DATA_BITS-1:0] pkt_data_q, pkt_data_d;
    logic                 pkt_valid_q, pkt_valid_d;
    logic                 pkt_last_q, pkt_last_d;
    logic                 pkt_good_q, pkt_good_d;
    logic                 pkt_bad_q, pkt_bad_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [15:0]          good_cnt_q, good_cnt_d;
    logic [15:0]          bad_cnt_q, bad_cnt_d;
    logic [DATA_BITS-1:0] mem_q [DEPTH];

    logic                 pop_s;
    logic                 in_frame_s;
    logic                 len_bad_s;
    logic                 timeout_s;
    logic                 bad_s;
    logic [1:0]           bad_code_s;
    logic                 mem_we_s;
    logic [LW-1:0]        len_m1_s;
    logic [LW-1:0]        rd_nxt_s;

    // FWFT FIFO: the head byte is consumed in the same cycle rd_uart is high; EMIT never pops.
    always_comb begin
        in_frame_s = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
        pop_s      = reset && !bus.rx_empty && (in_frame_s || (state_q == ST_HUNT));
        len_bad_s  = (bus.rd_data == {DATA_BITS{1'b0}}) || (32'(bus.rd_data) > 32'(MAX_LEN));
        len_m1_s   = len_q - LW'(1);
        rd_nxt_s   = rd_idx_q + LW'(1);
    end

`ifdef PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer_q, timer_d;

    // Inter-byte timer: counts idle cycles only while a frame is partially received.
    always_comb begin
        timer_d   = timer_q;
        timeout_s = 1'b0;
        if (pop_s || !in_frame_s) begin
            timer_d = {TW{1'b0}};
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timer_d   = {TW{1'b0}};
            timeout_s = 1'b1;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Timer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= {TW{1'b0}};
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    // Without the timer a partial frame waits indefinitely for its next byte.
    always_comb begin
        timeout_s = 1'b0;
    end
`endif

    // Frame parser / emitter next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        rd_idx_d    = rd_idx_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = pkt_valid_q;
        pkt_last_d  = pkt_last_q;
        pkt_good_d  = 1'b0;
        bad_s       = 1'b0;
        bad_code_s  = ERR_RX;
        mem_we_s    = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (pop_s && !bus.rx_err && (bus.rd_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_LEN: begin
                if (pop_s) begin
                    if (bus.rx_err) begin
                        bad_s      = 1'b1;
                        bad_code_s = ERR_RX;
                        state_d    = ST_HUNT;
                    end else if (len_bad_s) begin
                        bad_s      = 1'b1;
                        bad_code_s = ERR_LEN;
                        state_d    = ST_HUNT;
                    end else begin
                        len_d   = bus.rd_data[LW-1:0];
                        chk_d   = bus.rd_data;
                        idx_d   = {LW{1'b0}};
                        state_d = ST_PAYLOAD;
                    end
                end else if (timeout_s) begin
                    bad_s      = 1'b1;
                    bad_code_s = ERR_TMO;
                    state_d    = ST_HUNT;
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (pop_s) begin
                    if (bus.rx_err) begin
                        bad_s      = 1'b1;
                        bad_code_s = ERR_RX;
                        state_d    = ST_HUNT;
                    end else begin
                        mem_we_s = 1'b1;
                        chk_d    = chk_q ^ bus.rd_data;
                        idx_d    = idx_q + LW'(1);
                        if (idx_q == len_m1_s) begin
                            state_d = ST_CHK;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end else if (timeout_s) begin
                    bad_s      = 1'b1;
                    bad_code_s = ERR_TMO;
                    state_d    = ST_HUNT;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CHK: begin
                if (pop_s) begin
                    if (bus.rx_err) begin
                        bad_s      = 1'b1;
                        bad_code_s = ERR_RX;
                        state_d    = ST_HUNT;
                    end else if (bus.rd_data == chk_q) begin
                        pkt_good_d = 1'b1;
                        rd_idx_d   = {LW{1'b0}};
                        state_d    = ST_EMIT;
                    end else begin
                        bad_s      = 1'b1;
                        bad_code_s = ERR_CHK;
                        state_d    = ST_HUNT;
                    end
                end else if (timeout_s) begin
                    bad_s      = 1'b1;
                    bad_code_s = ERR_TMO;
                    state_d    = ST_HUNT;
                end else begin
                    state_d = ST_CHK;
                end
            end
            ST_EMIT: begin
                // First cycle after pkt_good loads byte 0; afterwards advance only on transfer.
                if (!pkt_valid_q) begin
                    pkt_valid_d = 1'b1;
                    pkt_data_d  = mem_q[rd_idx_q[IW-1:0]];
                    pkt_last_d  = (rd_idx_q == len_m1_s);
                end else if (bus.pkt_ready) begin
                    if (pkt_last_q) begin
                        pkt_valid_d = 1'b0;
                        pkt_last_d  = 1'b0;
                        state_d     = ST_HUNT;
                    end else begin
                        rd_idx_d   = rd_nxt_s;
                        pkt_data_d = mem_q[rd_nxt_s[IW-1:0]];
                        pkt_last_d = (rd_nxt_s == len_m1_s);
                    end
                end else begin
                    pkt_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_HUNT;
                pkt_valid_d = 1'b0;
                pkt_last_d  = 1'b0;
            end
        endcase

        pkt_bad_d  = bad_s;
        err_code_d = bad_s ? bad_code_s : err_code_q;
        good_cnt_d = (pkt_good_d && (good_cnt_q != 16'hFFFF)) ? (good_cnt_q + 16'd1) : good_cnt_q;
        bad_cnt_d  = (pkt_bad_d && (bad_cnt_q != 16'hFFFF)) ? (bad_cnt_q + 16'd1) : bad_cnt_q;
    end

    // State, control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_HUNT;
            len_q       <= {LW{1'b0}};
            idx_q       <= {LW{1'b0}};
            rd_idx_q    <= {LW{1'b0}};
            chk_q       <= {DATA_BITS{1'b0}};
            pkt_data_q  <= {DATA_BITS{1'b0}};
            pkt_valid_q <= 1'b0;
            pkt_last_q  <= 1'b0;
            pkt_good_q  <= 1'b0;
            pkt_bad_q   <= 1'b0;
            err_code_q  <= 2'b00;
            good_cnt_q  <= 16'd0;
            bad_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            rd_idx_q    <= rd_idx_d;
            chk_q       <= chk_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_last_q  <= pkt_last_d;
            pkt_good_q  <= pkt_good_d;
            pkt_bad_q   <= pkt_bad_d;
            err_code_q  <= err_code_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    // Payload buffer; contents are meaningless until a frame has been parsed, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[idx_q[IW-1:0]] <= bus.rd_data;
        end
    end

    assign bus.rd_uart   = pop_s;
    assign bus.pkt_data  = pkt_data_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.pkt_last  = pkt_last_q;
    assign bus.pkt_good  = pkt_good_q;
    assign bus.pkt_bad   = pkt_bad_q;
    assign bus.err_code  = err_code_q;
    assign bus.good_cnt  = good_cnt_q;
    assign bus.bad_cnt   = bad_cnt_q;

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Directed bench for uart_rx_packetizer: a queue models the FWFT RX FIFO, a monitor collects the
// payload stream and pulses, and each scenario task checks its own expected values.
module tb_uart_rx_packetizer;

    logic clk;
    logic rst_n;

    uart_rx_packetizer_if #(.DATA_BITS(8)) bus ();

    uart_rx_packetizer #(
        .DATA_BITS(8), .MAX_LEN(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .reset(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_good = 0;
    int exp_bad = 0;

    logic [8:0] fifo [$];     // {rx_err, byte}
    logic [8:0] rx_bytes [$]; // {pkt_last, pkt_data}
    int good_pulses = 0;
    int bad_pulses = 0;
    logic [1:0] last_err = 2'b00;
    int emit_pops = 0;
    int pop_empty = 0;
    int hold_viol = 0;
    int lat_viol = 0;
    logic prev_stall = 1'b0;
    logic prev_good = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic prev_last = 1'b0;

    // FIFO model drives the head on the falling edge; outputs are sampled 1 time unit later.
    initial begin
        forever begin
            @(negedge clk);
            if (fifo.size() > 0) begin
                bus.rx_empty = 1'b0;
                bus.rx_err   = fifo[0][8];
                bus.rd_data  = fifo[0][7:0];
            end else begin
                bus.rx_empty = 1'b1;
                bus.rx_err   = 1'b0;
                bus.rd_data  = 8'h00;
            end
            #1;
            if (bus.rd_uart) begin
                if (fifo.size() > 0) void'(fifo.pop_front());
                else pop_empty++;
            end
            if (rst_n) begin
                if (bus.rd_uart && (bus.pkt_valid || bus.pkt_good)) emit_pops++;
                if (bus.pkt_valid && bus.pkt_ready) rx_bytes.push_back({bus.pkt_last, bus.pkt_data});
                if (bus.pkt_good) good_pulses++;
                if (bus.pkt_bad) begin
                    bad_pulses++;
                    last_err = bus.err_code;
                end
                if (prev_stall && (!bus.pkt_valid || bus.pkt_data != prev_data || bus.pkt_last != prev_last))
                    hold_viol++;
                if ((prev_good && !bus.pkt_valid) || (bus.pkt_good && bus.pkt_valid)) lat_viol++;
            end
            prev_stall = rst_n && bus.pkt_valid && !bus.pkt_ready;
            prev_good  = rst_n && bus.pkt_good;
            prev_data  = bus.pkt_data;
            prev_last  = bus.pkt_last;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [7:0] b, input logic e = 1'b0);
        fifo.push_back({e, b});
    endtask

    task automatic wait_drain(input int n_bytes, input string tag);
        int k;
        k = 0;
        while ((fifo.size() != 0 || rx_bytes.size() < n_bytes || bus.pkt_valid) && k < 1000) begin
            cyc(1);
            k++;
        end
        checks++;
        if (k >= 1000) begin
            errors++;
            $display("FAIL %s drain timeout: fifo=%0d got_bytes=%0d need_bytes=%0d", tag, fifo.size(), rx_bytes.size(), n_bytes);
        end
        cyc(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pkt_ready = 1'b1;
        bus.rx_empty = 1'b1;
        bus.rx_err = 1'b0;
        bus.rd_data = 8'h00;
        push(8'hA5);
        cyc(3);
        checks++; if (bus.rd_uart !== 1'b0) begin errors++; $display("FAIL reset_rd_uart got %b want 0", bus.rd_uart); end
        checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_pkt_valid got %b want 0", bus.pkt_valid); end
        checks++; if (bus.pkt_last !== 1'b0) begin errors++; $display("FAIL reset_pkt_last got %b want 0", bus.pkt_last); end
        checks++; if (bus.pkt_good !== 1'b0 || bus.pkt_bad !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", bus.pkt_good, bus.pkt_bad); end
        checks++; if (bus.pkt_data !== 8'h00) begin errors++; $display("FAIL reset_pkt_data got %h want 00", bus.pkt_data); end
        checks++; if (bus.err_code !== 2'b00) begin errors++; $display("FAIL reset_err_code got %b want 00", bus.err_code); end
        checks++; if (bus.good_cnt !== 16'd0 || bus.bad_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", bus.good_cnt, bus.bad_cnt); end
        fifo.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_good_frame();
        logic [7:0] exp [3];
        int g0;
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        g0 = good_pulses;
        rx_bytes.delete();
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h03);
        wait_drain(3, "good_frame");
        exp_good++;
        checks++; if (good_pulses - g0 !== 1) begin errors++; $display("FAIL good_pulse_count got %0d want 1", good_pulses - g0); end
        checks++; if (rx_bytes.size() !== 3) begin errors++; $display("FAIL good_stream_len got %0d want 3", rx_bytes.size()); end
        for (int i = 0; i < 3 && i < rx_bytes.size(); i++) begin
            checks++;
            if (rx_bytes[i] !== {(i == 2), exp[i]}) begin errors++; $display("FAIL good_byte%0d got %h want %h", i, rx_bytes[i], {(i == 2), exp[i]}); end
        end
        checks++; if (bus.good_cnt !== 16'(exp_good)) begin errors++; $display("FAIL good_cnt got %0d want %0d", bus.good_cnt, exp_good); end
    endtask

    task automatic test_bad_chk();
        int b0;
        b0 = bad_pulses;
        rx_bytes.delete();
        push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h00);
        wait_drain(0, "bad_chk");
        exp_bad++;
        checks++; if (bad_pulses - b0 !== 1) begin errors++; $display("FAIL chk_bad_pulses got %0d want 1", bad_pulses - b0); end
        checks++; if (last_err !== 2'b10) begin errors++; $display("FAIL chk_err_code got %b want 10", last_err); end
        checks++; if (rx_bytes.size() !== 0) begin errors++; $display("FAIL chk_no_output got %0d bytes want 0", rx_bytes.size()); end
        checks++; if (bus.bad_cnt !== 16'(exp_bad)) begin errors++; $display("FAIL chk_bad_cnt got %0d want %0d", bus.bad_cnt, exp_bad); end
    endtask

    task automatic test_bad_len();
        int b0;
        b0 = bad_pulses;
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h00);
        wait_drain(0, "len_zero");
        exp_bad++;
        checks++; if (bad_pulses - b0 !== 1) begin errors++; $display("FAIL len0_bad_pulses got %0d want 1", bad_pulses - b0); end
        checks++; if (last_err !== 2'b01) begin errors++; $display("FAIL len0_err_code got %b want 01", last_err); end
        push(8'hA5); push(8'h11);
        wait_drain(0, "len_17");
        exp_bad++;
        checks++; if (bad_pulses - b0 !== 2) begin errors++; $display("FAIL len17_bad_pulses got %0d want 2", bad_pulses - b0); end
        checks++; if (last_err !== 2'b01) begin errors++; $display("FAIL len17_err_code got %b want 01", last_err); end
        checks++; if (bus.bad_cnt !== 16'(exp_bad)) begin errors++; $display("FAIL len_bad_cnt got %0d want %0d", bus.bad_cnt, exp_bad); end
    endtask

    task automatic test_max_len();
        rx_bytes.delete();
        push(8'hA5); push(8'h10);
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'h10);
        wait_drain(16, "max_len");
        exp_good++;
        checks++; if (rx_bytes.size() !== 16) begin errors++; $display("FAIL maxlen_stream_len got %0d want 16", rx_bytes.size()); end
        for (int i = 0; i < 16 && i < rx_bytes.size(); i++) begin
            checks++;
            if (rx_bytes[i] !== {(i == 15), 8'(i)}) begin errors++; $display("FAIL maxlen_byte%0d got %h want %h", i, rx_bytes[i], {(i == 15), 8'(i)}); end
        end
    endtask

    task automatic test_backpressure();
        int k;
        int bad_data;
        int bad_pop;
        int g0;
        g0 = good_pulses;
        rx_bytes.delete();
        @(negedge clk);
        bus.pkt_ready = 1'b0;
        push(8'hA5); push(8'h01); push(8'hA5); push(8'hA4);
        push(8'hA5); push(8'h01); push(8'h55); push(8'h54);
        k = 0;
        while (!bus.pkt_valid && k < 100) begin cyc(1); k++; end
        checks++; if (k >= 100) begin errors++; $display("FAIL bp_valid_timeout got no pkt_valid want pkt_valid"); end
        bad_data = 0;
        bad_pop = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.pkt_data !== 8'hA5 || bus.pkt_last !== 1'b1 || bus.pkt_valid !== 1'b1) bad_data++;
            if (bus.rd_uart !== 1'b0) bad_pop++;
            cyc(1);
        end
        checks++; if (bad_data !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad_data); end
        checks++; if (bad_pop !== 0) begin errors++; $display("FAIL bp_rd_uart got %0d pop cycles want 0", bad_pop); end
        checks++; if (fifo.size() !== 4) begin errors++; $display("FAIL bp_fifo_level got %0d want 4", fifo.size()); end
        @(negedge clk);
        bus.pkt_ready = 1'b1;
        wait_drain(2, "backpressure");
        exp_good += 2;
        checks++; if (good_pulses - g0 !== 2) begin errors++; $display("FAIL bp_good_pulses got %0d want 2", good_pulses - g0); end
        checks++; if (rx_bytes.size() !== 2) begin errors++; $display("FAIL bp_stream_len got %0d want 2", rx_bytes.size()); end
        if (rx_bytes.size() == 2) begin
            checks++; if (rx_bytes[0] !== 9'h1A5) begin errors++; $display("FAIL bp_byte0 got %h want 1a5", rx_bytes[0]); end
            checks++; if (rx_bytes[1] !== 9'h155) begin errors++; $display("FAIL bp_byte1 got %h want 155", rx_bytes[1]); end
        end
    endtask

    task automatic test_rx_err();
        int b0;
        int g0;
        b0 = bad_pulses;
        g0 = good_pulses;
        rx_bytes.delete();
        push(8'hA5); push(8'h02); push(8'h33, 1'b1);
        push(8'hA5); push(8'h01); push(8'h7E); push(8'h7F);
        wait_drain(1, "rx_err");
        exp_bad++;
        exp_good++;
        checks++; if (bad_pulses - b0 !== 1) begin errors++; $display("FAIL rxerr_bad_pulses got %0d want 1", bad_pulses - b0); end
        checks++; if (last_err !== 2'b00) begin errors++; $display("FAIL rxerr_err_code got %b want 00", last_err); end
        checks++; if (rx_bytes.size() !== 1 || rx_bytes[0] !== 9'h17E) begin errors++; $display("FAIL rxerr_recover got n=%0d want 1 byte 17e", rx_bytes.size()); end
        // An errored sync byte while hunting is discarded without any pulse.
        b0 = bad_pulses;
        rx_bytes.delete();
        push(8'hA5, 1'b1); push(8'hA5); push(8'h01); push(8'h3C); push(8'h3D);
        wait_drain(1, "hunt_err");
        exp_good++;
        checks++; if (bad_pulses - b0 !== 0) begin errors++; $display("FAIL hunt_err_silent got %0d bad pulses want 0", bad_pulses - b0); end
        checks++; if (rx_bytes.size() !== 1 || rx_bytes[0] !== 9'h13C) begin errors++; $display("FAIL hunt_err_frame got n=%0d want 1 byte 13c", rx_bytes.size()); end
        checks++; if (good_pulses - g0 !== 2) begin errors++; $display("FAIL rxerr_good_pulses got %0d want 2", good_pulses - g0); end
    endtask

    task automatic test_back_to_back();
        rx_bytes.delete();
        push(8'hA5); push(8'h02); push(8'h01); push(8'h02); push(8'h01);
        push(8'hA5); push(8'h01); push(8'hFF); push(8'hFE);
        wait_drain(3, "back_to_back");
        exp_good += 2;
        checks++; if (rx_bytes.size() !== 3) begin errors++; $display("FAIL b2b_stream_len got %0d want 3", rx_bytes.size()); end
        if (rx_bytes.size() == 3) begin
            checks++; if (rx_bytes[0] !== 9'h001 || rx_bytes[1] !== 9'h102 || rx_bytes[2] !== 9'h1FF) begin
                errors++; $display("FAIL b2b_bytes got %h %h %h want 001 102 1ff", rx_bytes[0], rx_bytes[1], rx_bytes[2]);
            end
        end
    endtask

    task automatic test_timeout();
        int b0;
        b0 = bad_pulses;
        rx_bytes.delete();
        push(8'hA5); push(8'h02); push(8'h01);
        cyc(40);
        checks++; if (bad_pulses - b0 !== 0) begin errors++; $display("FAIL tmo_early got %0d bad pulses want 0", bad_pulses - b0); end
`ifdef PKT_TIMEOUT_EN
        cyc(40);
        exp_bad++;
        checks++; if (bad_pulses - b0 !== 1) begin errors++; $display("FAIL tmo_bad_pulses got %0d want 1", bad_pulses - b0); end
        checks++; if (last_err !== 2'b11) begin errors++; $display("FAIL tmo_err_code got %b want 11", last_err); end
        push(8'hA5); push(8'h01); push(8'h21); push(8'h20);
        wait_drain(1, "tmo_recover");
        exp_good++;
        checks++; if (rx_bytes.size() !== 1 || rx_bytes[0] !== 9'h121) begin errors++; $display("FAIL tmo_recover got n=%0d want 1 byte 121", rx_bytes.size()); end
`else
        cyc(160);
        checks++; if (bad_pulses - b0 !== 0) begin errors++; $display("FAIL notmo_wait got %0d bad pulses want 0", bad_pulses - b0); end
        push(8'h02); push(8'h01);
        wait_drain(2, "notmo_complete");
        exp_good++;
        checks++; if (rx_bytes.size() !== 2 || rx_bytes[1] !== 9'h102) begin errors++; $display("FAIL notmo_frame got n=%0d want 2 bytes ending 102", rx_bytes.size()); end
`endif
    endtask

    task automatic test_counters();
        checks++; if (bus.good_cnt !== 16'(exp_good)) begin errors++; $display("FAIL final_good_cnt got %0d want %0d", bus.good_cnt, exp_good); end
        checks++; if (bus.bad_cnt !== 16'(exp_bad)) begin errors++; $display("FAIL final_bad_cnt got %0d want %0d", bus.bad_cnt, exp_bad); end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_stability got %0d violations want 0", hold_viol); end
        checks++; if (lat_viol !== 0) begin errors++; $display("FAIL good_to_valid_latency got %0d violations want 0", lat_viol); end
        checks++; if (emit_pops !== 0) begin errors++; $display("FAIL emit_pops got %0d want 0", emit_pops); end
        checks++; if (pop_empty !== 0) begin errors++; $display("FAIL pop_when_empty got %0d want 0", pop_empty); end
    endtask

    task automatic test_reset_mid_emit();
        int k;
        int g0;
        @(negedge clk);
        bus.pkt_ready = 1'b0;
        push(8'hA5); push(8'h01); push(8'h42); push(8'h43);
        k = 0;
        while (!bus.pkt_valid && k < 100) begin cyc(1); k++; end
        checks++; if (k >= 100) begin errors++; $display("FAIL rst_emit_valid_timeout got no pkt_valid want pkt_valid"); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.pkt_valid !== 1'b0 || bus.good_cnt !== 16'd0 || bus.bad_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_emit_abort got valid=%b cnt=%0d/%0d want 0 0/0", bus.pkt_valid, bus.good_cnt, bus.bad_cnt);
        end
        cyc(2);
        @(negedge clk);
        rst_n = 1'b1;
        g0 = good_pulses;
        cyc(10);
        checks++; if (bus.pkt_valid !== 1'b0 || good_pulses !== g0) begin errors++; $display("FAIL rst_emit_discard got valid=%b pulses=%0d want 0 0", bus.pkt_valid, good_pulses - g0); end
        @(negedge clk);
        bus.pkt_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_bad_len();
        test_max_len();
        test_backpressure();
        test_rx_err();
        test_back_to_back();
        test_timeout();
        test_counters();
        test_reset_mid_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
